matrix_load_sequencer: RTL

//   Command-side driver for the matrix stack controller. Accepts stack commands
//   (load, load-identity, pop, set-mode) and a 32-bit word stream, packs 16
//   row-major floats into four 128-bit rows, then replays them onto the stack's

---
 rtl/matrix_load_sequencer_pkg.sv | 36 +++
 rtl/matrix_load_sequencer_if.sv | 32 +++
 rtl/matrix_load_sequencer_row_packer.sv | 44 ++++
 rtl/matrix_load_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/matrix_load_sequencer_pkg.sv
// Shared types and constants for the matrix load sequencer: command encodings,
// stack modes, FSM states and identity-row values.
package matrix_load_sequencer_pkg;

    localparam int WORD_W = 32;
    localparam int N_DIM  = 4;
    localparam int ROW_W  = N_DIM * WORD_W;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'd0,
        OP_LOAD_ID  = 2'd1,
        OP_POP      = 2'd2,
        OP_SET_MODE = 2'd3
    } cmd_op_e;

    localparam logic MODE_MODELVIEW  = 1'b0;
    localparam logic MODE_PROJECTION = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_EMIT0  = 3'd2,
        ST_EMIT1  = 3'd3,
        ST_EMIT2  = 3'd4,
        ST_EMIT3  = 3'd5,
        ST_STROBE = 3'd6
    } seq_state_e;

    // 1.0f on the diagonal, column 0 in the most significant word
    localparam logic [WORD_W-1:0] FLOAT_ONE = 32'h3F80_0000;
    localparam logic [ROW_W-1:0]  ID_ROW0   = {FLOAT_ONE, 96'h0};
    localparam logic [ROW_W-1:0]  ID_ROW1   = {32'h0, FLOAT_ONE, 64'h0};
    localparam logic [ROW_W-1:0]  ID_ROW2   = {64'h0, FLOAT_ONE, 32'h0};
    localparam logic [ROW_W-1:0]  ID_ROW3   = {96'h0, FLOAT_ONE};

endpackage

// File: rtl/matrix_load_sequencer_if.sv
// Command/word stream from the GL decoder plus the load port toward the
// matrix stack controller.
interface matrix_load_sequencer_if;
    import matrix_load_sequencer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    cmd_op_e           cmd_op;
    logic              cmd_mode;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic              matrix_mode;
    logic              load_en;
    logic              load_id_en;
    logic              pop_en;
    logic [ROW_W-1:0]  data_in;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_mode, word_valid, word_data,
        input  cmd_ready, word_ready, matrix_mode, load_en, load_id_en,
               pop_en, data_in, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mode, word_valid, word_data,
        output cmd_ready, word_ready, matrix_mode, load_en, load_id_en,
               pop_en, data_in, busy
    );

endinterface

// File: rtl/matrix_load_sequencer_row_packer.sv
// Packs 16 row-major words into four 128-bit rows; fill_done_o flags the
// write of the final word so the caller can start emitting on the next cycle.
module matrix_load_sequencer_row_packer
    import matrix_load_sequencer_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear_i,
    input  logic                            wr_en_i,
    input  logic [WORD_W-1:0]               wr_data_i,
    output logic                            fill_done_o,
    output logic [N_DIM-1:0][ROW_W-1:0]     rows_o
);

    localparam int N_WORDS = N_DIM * N_DIM;
    localparam int CNT_W   = $clog2(N_WORDS);

    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] words_q [N_WORDS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < N_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (wr_en_i) begin
            words_q[cnt_q] <= wr_data_i;
            cnt_q          <= cnt_q + CNT_W'(1);
        end
    end

    assign fill_done_o = wr_en_i && (cnt_q == CNT_W'(N_WORDS - 1));

    // word index = row*N_DIM + col; col 0 occupies the top of the row
    for (genvar r = 0; r < N_DIM; r++) begin : g_row
        for (genvar c = 0; c < N_DIM; c++) begin : g_col
            assign rows_o[r][(N_DIM-1-c)*WORD_W +: WORD_W] = words_q[r*N_DIM + c];
        end
    end

endmodule

// File: rtl/matrix_load_sequencer.sv
// Command-side driver for the matrix stack: collects a 16-word matrix and
// replays it as four back-to-back rows, or issues single-cycle pop/identity strobes.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | accepting commands; SET_MODE updates matrix_mode in place
// ST_FILL   | accepting matrix words until the 16th arrives
// ST_EMIT0  | load_en high, row 0 on data_in
// ST_EMIT1  | row 1 on data_in
// ST_EMIT2  | row 2 on data_in
// ST_EMIT3  | row 3 on data_in
// ST_STROBE | pop_en or load_id_en high for this single cycle
module matrix_load_sequencer
    import matrix_load_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    matrix_load_sequencer_if.slave bus
);

    seq_state_e                  state_q;
    logic                        load_en_q;
    logic                        load_id_en_q;
    logic                        pop_en_q;
    logic                        mode_q;
    logic [ROW_W-1:0]            data_q;

    logic                        cmd_fire;
    logic                        word_fire;
    logic                        pack_clear;
    logic                        fill_done;
    logic [N_DIM-1:0][ROW_W-1:0] rows;

    assign cmd_fire   = bus.cmd_valid && (state_q == ST_IDLE);
    assign word_fire  = bus.word_valid && (state_q == ST_FILL);
    assign pack_clear = cmd_fire && (bus.cmd_op == OP_LOAD);

    matrix_load_sequencer_row_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (pack_clear),
        .wr_en_i     (word_fire),
        .wr_data_i   (bus.word_data),
        .fill_done_o (fill_done),
        .rows_o      (rows)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            load_en_q    <= 1'b0;
            load_id_en_q <= 1'b0;
            pop_en_q     <= 1'b0;
            mode_q       <= MODE_MODELVIEW;
            data_q       <= '0;
        end else begin
            load_en_q    <= 1'b0;
            load_id_en_q <= 1'b0;
            pop_en_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        case (bus.cmd_op)
                            OP_LOAD:     state_q <= ST_FILL;
                            OP_LOAD_ID: begin
                                state_q      <= ST_STROBE;
                                load_id_en_q <= 1'b1;
                            end
                            OP_POP: begin
                                state_q  <= ST_STROBE;
                                pop_en_q <= 1'b1;
                            end
                            OP_SET_MODE: mode_q <= bus.cmd_mode;
                            default:     state_q <= ST_IDLE;
                        endcase
                    end
                end
                ST_FILL: begin
                    // row 0 is already complete when the last word (row 3) lands
                    if (fill_done) begin
                        state_q   <= ST_EMIT0;
                        load_en_q <= 1'b1;
                        data_q    <= rows[0];
                    end
                end
                ST_EMIT0: begin
                    state_q <= ST_EMIT1;
                    data_q  <= rows[1];
                end
                ST_EMIT1: begin
                    state_q <= ST_EMIT2;
                    data_q  <= rows[2];
                end
                ST_EMIT2: begin
                    state_q <= ST_EMIT3;
                    data_q  <= rows[3];
                end
                ST_EMIT3:  state_q <= ST_IDLE;
                ST_STROBE: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.word_ready  = (state_q == ST_FILL);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.matrix_mode = mode_q;
    assign bus.load_en     = load_en_q;
    assign bus.load_id_en  = load_id_en_q;
    assign bus.pop_en      = pop_en_q;
    assign bus.data_in     = data_q;

endmodule
